// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sequencer sharing one signed divider among
// N_REQ requesters.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req[N_REQ]                     level request per channel
//   dividend_in, divisor_in        per-channel operands, channel k at [k*W +: W]
//   ack[N_REQ]                     one-cycle pulse to the serviced channel
//   quotient_out, reminder_out     result, valid with ack, held until next ack
//   err                            valid with ack: divide-by-zero or timeout
//   busy                           high whenever the FSM is not IDLE
//   grant_id                       channel currently or last serviced
//   div_start, div_dividend,
//   div_divisor                    divider request side (operands stable with start)
//   div_done, div_quotient,
//   div_reminder                   divider response side
module divider_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*W-1:0]         dividend_in,
  input  logic [N_REQ*W-1:0]         divisor_in,
  output logic [N_REQ-1:0]           ack,
  output logic [W-1:0]               quotient_out,
  output logic [W-1:0]               reminder_out,
  output logic                       err,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       div_start,
  output logic [W-1:0]               div_dividend,
  output logic [W-1:0]               div_divisor,
  input  logic                       div_done,
  input  logic [W-1:0]               div_quotient,
  input  logic [W-1:0]               div_reminder
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDW-1:0] ptr, ptr_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;

  logic [N_REQ-1:0] ack_nxt;
  logic [W-1:0]     quotient_nxt, reminder_nxt;
  logic             err_nxt, busy_nxt, start_nxt;
  logic [IDW-1:0]   grant_nxt;
  logic [W-1:0]     dividend_nxt, divisor_nxt;

  // Unpacked operand views of the flat channel buses
  logic [W-1:0] dvd_arr [N_REQ];
  logic [W-1:0] dvs_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      dvd_arr[i] = dividend_in[i*W +: W];
      dvs_arr[i] = divisor_in[i*W +: W];
    end
  end

  // Round-robin pick: first requesting channel at or above ptr, wrapping
  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  logic [IDW-1:0] cand;
  int unsigned    scan;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    scan      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan = (32'(ptr) + i) % N_REQ;
      cand = IDW'(scan);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  logic [W-1:0] sel_dividend, sel_divisor;
  logic         sel_div_zero;
  logic [IDW-1:0] ptr_after_grant;

  assign sel_dividend    = dvd_arr[arb_idx];
  assign sel_divisor     = dvs_arr[arb_idx];
  assign sel_div_zero    = (sel_divisor == '0);
  assign ptr_after_grant = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arb_found) state_nxt = sel_div_zero ? RESP : RUN;
      RUN:  if (div_done || (cnt == CNT_MAX)) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath decode: next values of every registered output
  always_comb begin
    ack_nxt      = '0;
    quotient_nxt = quotient_out;
    reminder_nxt = reminder_out;
    err_nxt      = err;
    busy_nxt     = (state_nxt != IDLE);
    start_nxt    = div_start;
    grant_nxt    = grant_id;
    dividend_nxt = div_dividend;
    divisor_nxt  = div_divisor;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    case (state)
      IDLE: begin
        if (arb_found) begin
          grant_nxt    = arb_idx;
          dividend_nxt = sel_dividend;
          divisor_nxt  = sel_divisor;
          if (sel_div_zero) begin
            // Short-circuit: the divider never sees this operation
            quotient_nxt     = '1;
            reminder_nxt     = sel_dividend;
            err_nxt          = 1'b1;
            ack_nxt[arb_idx] = 1'b1;
          end else begin
            start_nxt = 1'b1;
            cnt_nxt   = '0;
          end
        end
      end
      RUN: begin
        // done wins over a timeout landing on the same cycle
        if (div_done) begin
          quotient_nxt      = div_quotient;
          reminder_nxt      = div_reminder;
          err_nxt           = 1'b0;
          start_nxt         = 1'b0;
          ack_nxt[grant_id] = 1'b1;
        end else if (cnt == CNT_MAX) begin
          quotient_nxt      = '0;
          reminder_nxt      = '0;
          err_nxt           = 1'b1;
          start_nxt         = 1'b0;
          ack_nxt[grant_id] = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP: begin
        ptr_nxt = ptr_after_grant;
      end
      default: begin
        start_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack          <= '0;
      quotient_out <= '0;
      reminder_out <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      ptr          <= '0;
      cnt          <= '0;
    end else begin
      ack          <= ack_nxt;
      quotient_out <= quotient_nxt;
      reminder_out <= reminder_nxt;
      err          <= err_nxt;
      busy         <= busy_nxt;
      grant_id     <= grant_nxt;
      div_start    <= start_nxt;
      div_dividend <= dividend_nxt;
      div_divisor  <= divisor_nxt;
      ptr          <= ptr_nxt;
      cnt          <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed bench for divider_arbiter with a behavioural
// signed divider stub (fixed latency, optional hang) and an ack scoreboard.
module tb_divider_arbiter;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 10;
  localparam int          LAT     = 3;

  logic                 clk;
  logic                 rst_n;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*W-1:0]   dividend_in;
  logic [N_REQ*W-1:0]   divisor_in;
  logic [N_REQ-1:0]     ack;
  logic [W-1:0]         quotient_out;
  logic [W-1:0]         reminder_out;
  logic                 err;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 div_start;
  logic [W-1:0]         div_dividend;
  logic [W-1:0]         div_divisor;
  logic                 div_done;
  logic [W-1:0]         div_quotient;
  logic [W-1:0]         div_reminder;

  divider_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .ack(ack), .quotient_out(quotient_out), .reminder_out(reminder_out),
    .err(err), .busy(busy), .grant_id(grant_id),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_reminder(div_reminder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider stub: done pulses LAT edges after start is first seen high
  logic       hang, stray_done, model_done, fired;
  int         mcnt;
  assign div_done = model_done | stray_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_done   <= 1'b0;
      fired        <= 1'b0;
      mcnt         <= 0;
      div_quotient <= '0;
      div_reminder <= '0;
    end else begin
      model_done <= 1'b0;
      if (!div_start) begin
        fired <= 1'b0;
        mcnt  <= 0;
      end else if (!fired && !hang) begin
        if (mcnt == LAT - 1) begin
          model_done <= 1'b1;
          fired      <= 1'b1;
          if (div_divisor != '0) begin
            div_quotient <= W'($signed(div_dividend) / $signed(div_divisor));
            div_reminder <= W'($signed(div_dividend) % $signed(div_divisor));
          end
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         ch;
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
  } exp_t;

  exp_t sb[$];

  task automatic push(input int ch, input logic [7:0] q, input logic [7:0] r, input logic e);
    exp_t x;
    x.ch = ch; x.q = q; x.r = r; x.e = e;
    sb.push_back(x);
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation
  exp_t       got;
  logic [3:0] exp_ack;
  always @(negedge clk) begin
    if (rst_n && ack != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        got     = sb.pop_front();
        exp_ack = 4'b0001 << got.ch;
        check("ack_channel", 32'(ack), 32'(exp_ack));
        check("quotient", 32'(quotient_out), 32'(got.q));
        check("remainder", 32'(reminder_out), 32'(got.r));
        check("err", 32'(err), 32'(got.e));
      end
    end
  end

  // Requester behaviour: drop req on the edge that samples ack unless kept
  logic [N_REQ-1:0] keep;
  int               ack_cnt;

  task automatic step();
    @(negedge clk);
    if (ack != '0) ack_cnt++;
    for (int k = 0; k < int'(N_REQ); k++)
      if (ack[k] && !keep[k]) req[k] = 1'b0;
  endtask

  task automatic set_ch(input int k, input logic [7:0] a, input logic [7:0] b);
    dividend_in[k*W +: W] = a;
    divisor_in[k*W +: W]  = b;
  endtask

  task automatic wait_ack(input string tag, input int budget, output int n);
    n = 0;
    while (ack == '0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(ack != '0), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = '0; dividend_in = '0; divisor_in = '0;
    hang = 1'b0; stray_done = 1'b0; keep = '0; ack_cnt = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_start", 32'(div_start), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_q", 32'(quotient_out), 32'h0);
    check("rst_r", 32'(reminder_out), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ops", 32'({div_dividend, div_divisor}), 32'h0);
    rst_n = 1'b1;
    step();

    // Ch0 9/6: start one cycle after grant, ack LAT+1 cycles after grant
    set_ch(0, 8'd9, 8'd6);
    push(0, 8'd1, 8'd3, 1'b0);
    req[0] = 1'b1;
    step();
    check("t1_start", 32'(div_start), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_grant", 32'(grant_id), 32'd0);
    check("t1_ops", 32'({div_dividend, div_divisor}), 32'h0906);
    wait_ack("t1_ack_seen", 30, n);
    check("t1_latency", 32'(n), 32'(LAT + 1));
    check("t1_start_low_resp", 32'(div_start), 32'd0);
    step();
    check("t1_start_low_idle", 32'(div_start), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // done outside RUN is ignored
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    step();
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_start", 32'(div_start), 32'd0);

    // Ch1 57/0: short-circuited, no start, ack one cycle after grant
    set_ch(1, 8'd57, 8'd0);
    push(1, 8'hFF, 8'd57, 1'b1);
    req[1] = 1'b1;
    step();
    check("dbz_ack", 32'(ack), 32'b0010);
    check("dbz_no_start", 32'(div_start), 32'd0);
    step();
    check("dbz_idle", 32'(busy), 32'd0);

    // Ch2 with hung divider: start high TIMEOUT+1 cycles, then error ack
    hang = 1'b1;
    set_ch(2, 8'd20, 8'd3);
    push(2, 8'h00, 8'h00, 1'b1);
    req[2] = 1'b1;
    step();
    n = 0;
    while (div_start && n < 50) begin
      n++;
      step();
    end
    check("to_start_cycles", 32'(n), 32'(TIMEOUT + 1));
    check("to_ack", 32'(ack), 32'b0100);
    hang = 1'b0;
    step();

    // Next request after timeout is serviced normally: 100/7
    set_ch(3, 8'd100, 8'd7);
    push(3, 8'd14, 8'd2, 1'b0);
    req[3] = 1'b1;
    wait_drain("t_after_to", 40);
    step();

    // All four channels at once, pointer back at 0: serviced 0,1,2,3
    set_ch(0, 8'd9, 8'd6);
    set_ch(1, 8'd9, 8'hFA);
    set_ch(2, 8'hF7, 8'd6);
    set_ch(3, 8'hF7, 8'hFA);
    push(0, 8'd1, 8'd3, 1'b0);
    push(1, 8'hFF, 8'd3, 1'b0);
    push(2, 8'hFF, 8'hFD, 1'b0);
    push(3, 8'd1, 8'hFD, 1'b0);
    req = 4'hF;
    wait_drain("t_all4", 100);
    check("t_all4_req_dropped", 32'(req), 32'h0);
    step();

    // Ch0 re-requests, ch2 holds: alternates 0,2,0,2
    set_ch(0, 8'd9, 8'd6);
    set_ch(2, 8'hF7, 8'd6);
    push(0, 8'd1, 8'd3, 1'b0);
    push(2, 8'hFF, 8'hFD, 1'b0);
    push(0, 8'd1, 8'd3, 1'b0);
    push(2, 8'hFF, 8'hFD, 1'b0);
    keep = 4'b0101;
    ack_cnt = 0;
    req = 4'b0101;
    n = 0;
    while (ack_cnt < 3 && n < 100) begin
      step();
      n++;
    end
    check("t_alt_three_acks", 32'(ack_cnt), 32'd3);
    keep = '0;
    req[0] = 1'b0;
    wait_drain("t_alt", 40);
    step();
    check("t_alt_idle", 32'(busy), 32'd0);

    // Reset in the middle of RUN
    set_ch(1, 8'd50, 8'd5);
    req[1] = 1'b1;
    step();
    step();
    check("t_rst_running", 32'(div_start), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t_rst_start", 32'(div_start), 32'd0);
    check("t_rst_busy", 32'(busy), 32'd0);
    check("t_rst_ack", 32'(ack), 32'd0);
    req[1] = 1'b0;
    set_ch(3, 8'hF7, 8'd2);
    req[3] = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    push(3, 8'hFC, 8'hFF, 1'b0);
    step();
    check("t_rst_grant3", 32'(grant_id), 32'd3);
    wait_drain("t_rst_after", 40);
    step();
    check("t_final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
